// File: rtl/div_rem_unit_pkg.sv
// Shared definitions for the RV32M divide/remainder unit: funct3 encodings,
// FSM states and the fused-result tag payload.
package div_rem_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Operands, signedness and kind of the last completed iterative op, plus both results
    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            is_signed;
        logic            is_rem;
        logic [XLEN-1:0] quo;
        logic [XLEN-1:0] rmd;
    } div_tag_t;

endpackage

// File: rtl/div_rem_unit_if.sv
// Issue/result bus between the execute stage and the divide/remainder unit.
interface div_rem_unit_if;

    logic                                 start_i;
    logic [2:0]                           funct3_i;
    logic [div_rem_unit_pkg::XLEN-1:0]    rs1_i;
    logic [div_rem_unit_pkg::XLEN-1:0]    rs2_i;
    logic                                 kill_i;
    logic                                 busy_o;
    logic                                 valid_o;
    logic [div_rem_unit_pkg::XLEN-1:0]    result_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, kill_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, kill_i,
        output busy_o, valid_o, result_o
    );

endinterface

// File: rtl/div_rem_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract,
// keep the difference when it does not go negative.
module div_rem_unit_div_step
    import div_rem_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o_c,
    output logic            q_bit_o_c
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Extra top bit keeps the borrow visible even for divisors above 2^(XLEN-1)
    assign shifted   = {rem_i, bit_i};
    assign diff      = shifted - {1'b0, divisor_i};
    assign q_bit_o_c = ~diff[XLEN];
    assign rem_o_c   = q_bit_o_c ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_rem_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit with single-cycle divide-by-zero,
// signed-overflow and fused DIV<->REM fast paths.
module div_rem_unit
    import div_rem_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    div_rem_unit_if.slave bus
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvd_q, dvd_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [XLEN-1:0]  op_rs1_q, op_rs1_d;
    logic [XLEN-1:0]  op_rs2_q, op_rs2_d;
    logic             op_signed_q, op_signed_d;
    logic             op_rem_q, op_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             tag_valid_q, tag_valid_d;
    div_tag_t         tag_q, tag_d;

    logic            start_ok, in_signed, in_rem;
    logic            div_zero, sgn_ovf, fuse_hit, fast_hit;
    logic [XLEN-1:0] fast_res, abs_rs1, abs_rs2;
    logic [XLEN-1:0] step_rem, fix_quo, fix_rem;
    logic            step_q;

    // Issue decode and fast-path detection
    always_comb begin
        start_ok  = bus.start_i && (bus.funct3_i inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU});
        in_signed = ~bus.funct3_i[0];
        in_rem    = bus.funct3_i[1];
        div_zero  = (bus.rs2_i == '0);
        sgn_ovf   = in_signed && (bus.rs1_i == INT_MIN) && (bus.rs2_i == '1);
        fuse_hit  = tag_valid_q && (tag_q.rs1 == bus.rs1_i) && (tag_q.rs2 == bus.rs2_i)
                 && (tag_q.is_signed == in_signed) && (tag_q.is_rem != in_rem);
        fast_hit  = div_zero || sgn_ovf || fuse_hit;
        abs_rs1   = (in_signed && bus.rs1_i[XLEN-1]) ? -bus.rs1_i : bus.rs1_i;
        abs_rs2   = (in_signed && bus.rs2_i[XLEN-1]) ? -bus.rs2_i : bus.rs2_i;
        if (div_zero) begin
            fast_res = in_rem ? bus.rs1_i : '1;
        end else if (sgn_ovf) begin
            fast_res = in_rem ? '0 : INT_MIN;
        end else begin
            fast_res = in_rem ? tag_q.rmd : tag_q.quo;
        end
        fix_quo = neg_quo_q ? -dvd_q : dvd_q;
        fix_rem = neg_rem_q ? -rem_q : rem_q;
    end

    div_rem_unit_div_step u_div_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[XLEN-1]),
        .divisor_i (dvsr_q),
        .rem_o_c   (step_rem),
        .q_bit_o_c (step_q)
    );

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvsr_d      = dvsr_q;
        op_rs1_d    = op_rs1_q;
        op_rs2_d    = op_rs2_q;
        op_signed_d = op_signed_q;
        op_rem_d    = op_rem_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        valid_d     = 1'b0;
        result_d    = result_q;
        tag_valid_d = tag_valid_q;
        tag_d       = tag_q;

        if (bus.kill_i) begin
            state_d     = IDLE;
            tag_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start_ok && fast_hit) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = fast_res;
                    end else if (start_ok) begin
                        state_d     = CALC;
                        cnt_d       = CNT_W'(XLEN);
                        rem_d       = '0;
                        dvd_d       = abs_rs1;
                        dvsr_d      = abs_rs2;
                        op_rs1_d    = bus.rs1_i;
                        op_rs2_d    = bus.rs2_i;
                        op_signed_d = in_signed;
                        op_rem_d    = in_rem;
                        neg_quo_d   = in_signed && (bus.rs1_i[XLEN-1] ^ bus.rs2_i[XLEN-1]);
                        neg_rem_d   = in_signed && bus.rs1_i[XLEN-1];
                    end
                end
                CALC: begin
                    // Quotient bits enter at the bottom as dividend bits leave the top
                    rem_d = step_rem;
                    dvd_d = {dvd_q[XLEN-2:0], step_q};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    state_d     = DONE;
                    valid_d     = 1'b1;
                    result_d    = op_rem_q ? fix_rem : fix_quo;
                    tag_valid_d = 1'b1;
                    tag_d       = '{rs1: op_rs1_q, rs2: op_rs2_q, is_signed: op_signed_q,
                                    is_rem: op_rem_q, quo: fix_quo, rmd: fix_rem};
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == CALC) || (state_d == FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvsr_q      <= '0;
            op_rs1_q    <= '0;
            op_rs2_q    <= '0;
            op_signed_q <= 1'b0;
            op_rem_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvsr_q      <= dvsr_d;
            op_rs1_q    <= op_rs1_d;
            op_rs2_q    <= op_rs2_d;
            op_signed_q <= op_signed_d;
            op_rem_q    <= op_rem_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            tag_valid_q <= tag_valid_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed bench for div_rem_unit: a reference model feeds a scoreboard of
// expected results and latencies that is drained when valid_o pulses.
module tb_div_rem_unit;
    import div_rem_unit_pkg::*;

    localparam int TIMEOUT = 200;

    logic clk;
    logic rst_n;

    div_rem_unit_if dut_if ();

    div_rem_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          errors;
    logic [31:0] last_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result computed with 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return f3[1] ? r[31:0] : q[31:0];
    endfunction

    task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dut_if.start_i  = 1'b1;
        dut_if.funct3_i = f3;
        dut_if.rs1_i    = a;
        dut_if.rs2_i    = b;
        @(posedge clk);
        #1;
        dut_if.start_i = 1'b0;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input string name);
        exp_t e;
        e.res  = ref_model(f3, a, b);
        e.lat  = lat;
        e.name = name;
        sb.push_back(e);
        drive_start(f3, a, b);
    endtask

    // Waits for valid_o; optionally pokes a divide-by-zero start at cycle poke while busy
    task automatic collect(input int poke);
        exp_t e;
        int   lat;
        int   busy_cnt;
        lat      = 1;
        busy_cnt = 0;
        while (dut_if.valid_o !== 1'b1 && lat < TIMEOUT) begin
            if (dut_if.busy_o === 1'b1) busy_cnt++;
            if (lat == poke) begin
                dut_if.start_i  = 1'b1;
                dut_if.funct3_i = F3_DIV;
                dut_if.rs1_i    = 32'd7;
                dut_if.rs2_i    = 32'd0;
            end else begin
                dut_if.start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        dut_if.start_i = 1'b0;
        e = sb.pop_front();
        chk({e.name, " valid"}, 64'(dut_if.valid_o), 64'd1);
        chk({e.name, " latency"}, 64'(lat), 64'(e.lat));
        chk({e.name, " result"}, 64'(dut_if.result_o), 64'(e.res));
        chk({e.name, " busy_cycles"}, 64'(busy_cnt), 64'((e.lat == 1) ? 0 : e.lat - 1));
        chk({e.name, " busy_at_valid"}, 64'(dut_if.busy_o), 64'd0);
        last_res = e.res;
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input string name);
        issue(f3, a, b, lat, name);
        collect(0);
    endtask

    // Checks a quiet window: no valid pulse, not busy, result held
    task automatic quiet(input string name, input int cycles);
        int vcnt;
        int bcnt;
        vcnt = 0;
        bcnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (dut_if.valid_o !== 1'b0) vcnt++;
            if (dut_if.busy_o !== 1'b0) bcnt++;
        end
        chk({name, " no_valid"}, 64'(vcnt), 64'd0);
        chk({name, " no_busy"}, 64'(bcnt), 64'd0);
        chk({name, " result_held"}, 64'(dut_if.result_o), 64'(last_res));
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        last_res        = 32'd0;
        rst_n           = 1'b0;
        dut_if.start_i  = 1'b0;
        dut_if.funct3_i = 3'b000;
        dut_if.rs1_i    = 32'd0;
        dut_if.rs2_i    = 32'd0;
        dut_if.kill_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(dut_if.busy_o), 64'd0);
        chk("reset valid", 64'(dut_if.valid_o), 64'd0);
        chk("reset result", 64'(dut_if.result_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed divide then fused remainder
        run(F3_DIV, 32'hFFFF_FFF9, 32'h2, 34, "div_m7_2");
        run(F3_REM, 32'hFFFF_FFF9, 32'h2, 1, "rem_m7_2_fused");

        // Unsigned pair, then same operands signed is a miss
        run(F3_DIVU, 32'hFFFF_FFFF, 32'h10, 34, "divu_ffff_16");
        run(F3_REMU, 32'hFFFF_FFFF, 32'h10, 1, "remu_ffff_16_fused");
        run(F3_DIV, 32'hFFFF_FFFF, 32'h10, 34, "div_m1_16_nofuse");

        // Divide by zero
        run(F3_DIV, 32'd5, 32'd0, 1, "div_5_0");
        run(F3_REM, 32'd5, 32'd0, 1, "rem_5_0");
        run(F3_DIVU, 32'd5, 32'd0, 1, "divu_5_0");

        // Signed overflow, then unsigned with the same bits goes iterative
        run(F3_DIV, INT_MIN, 32'hFFFF_FFFF, 1, "div_ovf");
        run(F3_REM, INT_MIN, 32'hFFFF_FFFF, 1, "rem_ovf");
        run(F3_DIVU, INT_MIN, 32'hFFFF_FFFF, 34, "divu_min_max");
        run(F3_REMU, INT_MIN, 32'hFFFF_FFFF, 1, "remu_min_max_fused");
        quiet("after_fuse", 3);

        // Kill during CALC
        drive_start(F3_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        dut_if.kill_i = 1'b1;
        @(posedge clk);
        #1;
        dut_if.kill_i = 1'b0;
        chk("kill busy_next", 64'(dut_if.busy_o), 64'd0);
        chk("kill valid_next", 64'(dut_if.valid_o), 64'd0);
        quiet("after_kill", 40);
        run(F3_REM, 32'd100, 32'd7, 34, "rem_100_7");
        run(F3_DIV, 32'd100, 32'd7, 1, "div_100_7_fused");

        // Kill while idle drops the tag
        @(negedge clk);
        dut_if.kill_i = 1'b1;
        @(negedge clk);
        dut_if.kill_i = 1'b0;
        run(F3_DIV, 32'd100, 32'd7, 34, "div_100_7_after_kill");

        // Kill and start together: start dropped
        @(negedge clk);
        dut_if.start_i  = 1'b1;
        dut_if.kill_i   = 1'b1;
        dut_if.funct3_i = F3_DIVU;
        dut_if.rs1_i    = 32'd9;
        dut_if.rs2_i    = 32'd2;
        @(negedge clk);
        dut_if.start_i = 1'b0;
        dut_if.kill_i  = 1'b0;
        quiet("kill_and_start", 40);

        // Start while busy is ignored
        issue(F3_DIVU, 32'd1000, 32'd10, 34, "divu_1000_10_poked");
        collect(5);
        run(F3_DIV, 32'hFFFF_FF9C, 32'd7, 34, "div_m100_7");
        run(F3_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, "rem_m100_m7");
        run(F3_REMU, 32'h8000_0003, 32'h8000_0001, 34, "remu_big_divisor");

        // Asynchronous reset mid-CALC
        drive_start(F3_DIVU, 32'd777, 32'd5);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst busy", 64'(dut_if.busy_o), 64'd0);
        chk("async_rst valid", 64'(dut_if.valid_o), 64'd0);
        chk("async_rst result", 64'(dut_if.result_o), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_res = 32'd0;
        quiet("after_reset", 3);
        run(F3_DIVU, 32'd20, 32'd3, 34, "divu_20_3");
        run(F3_REMU, 32'd20, 32'd3, 1, "remu_20_3_fused");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
